// File: rtl/sha256_unit.sv
// sha256_unit -- iterative single-round SHA-256 compression core.
//
// One compression round per clock, sequenced externally: a shared controller
// drives the round index and the matching round constant to many units in
// lockstep. The edge with round==0 loads the chaining value and the message
// block. Edges with round 1..63 each perform compression step round-1. The
// final step (63) is combinational and is folded into Hout while round==0,
// so a block costs 64 clocks and the next block loads on the same edge that
// the digest is taken.
//
// Optional build macro: SHA256_UNIT_DEBUG_EN adds the dbg_state / dbg_wt
// observation ports. Without it those ports and their logic are absent and
// the core function is identical.
//
// Ports:
//   clk        in   1    rising-edge clock
//   reset_n    in   1    asynchronous active-low reset (clears S and W)
//   round      in   6    round index 0..63 from the shared controller
//   Kt         in   32   round constant K[round-1] (K[63] while round==0)
//   M          in   512  message block, word 0 = M[511:480]; sampled at round==0 edge
//   Hin        in   256  chaining value a..h (a = [255:224]); held for the block
//   Hout       out  256  Hin + next state, per 32-bit word, combinational
//   dbg_state  out  256  (SHA256_UNIT_DEBUG_EN) working state S
//   dbg_wt     out  32   (SHA256_UNIT_DEBUG_EN) current schedule word Wt

module sha256_unit (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [5:0]   round,
  input  logic [31:0]  Kt,
  input  logic [511:0] M,
  input  logic [255:0] Hin,
  output logic [255:0] Hout
`ifdef SHA256_UNIT_DEBUG_EN
  ,
  output logic [255:0] dbg_state,
  output logic [31:0]  dbg_wt
`endif
);

  // Sigma functions, rotations written out as concatenations.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Working state a..h (a in the top word) and the 16-word schedule window.
  // The schedule window holds the oldest word at the top: [511:480] is the
  // word consumed this round, [31:0] is the most recently generated one.
  logic [255:0] state_q;
  logic [511:0] sched_q;

  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  wt;
  logic [31:0]  t1, t2;
  logic [31:0]  w_new;
  logic [255:0] state_next;

  always_comb begin
    a = state_q[255:224];
    b = state_q[223:192];
    c = state_q[191:160];
    d = state_q[159:128];
    e = state_q[127:96];
    f = state_q[95:64];
    g = state_q[63:32];
    h = state_q[31:0];

    wt = sched_q[511:480];

    t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + Kt + wt;
    t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));

    state_next = {t1 + t2, a, b, c, d + t1, e, f, g};

    // Counting from the oldest word (position 0 at the top of the window):
    // positions 14, 9, 1 and 0 are W[t-2], W[t-7], W[t-15] and W[t-16].
    w_new = small_sigma1(sched_q[63:32]) + sched_q[223:192]
          + small_sigma0(sched_q[479:448]) + sched_q[511:480];
  end

  // Digest output: word-wise addition, no carry crosses a 32-bit boundary.
  always_comb begin
    Hout = '0;
    for (int i = 0; i < 8; i++) begin
      Hout[i*32 +: 32] = Hin[i*32 +: 32] + state_next[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
      sched_q <= '0;
    end else if (round == 6'd0) begin
      // Load edge: no compression happens here; step 63 of the previous
      // block was only ever visible combinationally on Hout.
      state_q <= Hin;
      sched_q <= M;
    end else begin
      state_q <= state_next;
      sched_q <= {sched_q[479:0], w_new};
    end
  end

`ifdef SHA256_UNIT_DEBUG_EN
  assign dbg_state = state_q;
  assign dbg_wt    = wt;
`endif

endmodule

// File: tb/tb_sha256_unit.sv
// tb_sha256_unit -- directed bench for sha256_unit.
//
// Two units run in lockstep from one round/Kt controller. Unit A hashes the
// directed blocks; unit B takes A's top digest word combinationally on its M
// input and the remaining bits from a register the bench fills at the
// round-0 edge, forming the second hash of a double-SHA.
//
// Ports: none (top-level bench).

module tb_sha256_unit;

  logic         clk;
  logic         reset_n;
  logic [5:0]   round;
  logic [31:0]  kt;
  logic [511:0] a_m;
  logic [255:0] a_hin;
  logic [255:0] a_hout;
  logic [479:0] b_m_low;
  logic [511:0] b_m;
  logic [255:0] b_hin;
  logic [255:0] b_hout;
  logic         lag;

  int total;
  int bad;

  logic [31:0] k_rom [0:63];

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] M_ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H_BTC =
    256'hdc6a3b8d_0c69421a_cb1a5434_e536f7d5_c3c1b9e4_4cbb9b8f_95f0172e_fc48d2df;
  localparam logic [511:0] M_BTC =
    {32'hdc141787, 32'h358b0553, 32'h535f0119, 32'h00000000, 32'h80000000, 320'd0, 32'h00000280};
  localparam logic [255:0] D_BTC =
    256'h0fc3bf25_9405a32f_d6d78a5e_6de88914_8edd4088_cc46a2eb_c604c45a_15fe7d15;
  localparam logic [255:0] D_DBL =
    256'h766f7950_56dd74d7_03b9173e_8d44223b_dbe3e0b2_9fe6a0eb_8ab33534_88c2565c;
  // State after compression step 0 of "abc" (FIPS 180-2 worked example).
  localparam logic [255:0] S_ABC_T0 =
    256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;

  assign b_m = {a_hout[255:224], b_m_low};

  sha256_unit u_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .round     (round),
    .Kt        (kt),
    .M         (a_m),
    .Hin       (a_hin),
    .Hout      (a_hout)
`ifdef SHA256_UNIT_DEBUG_EN
    ,
    .dbg_state (a_dbg_state),
    .dbg_wt    (a_dbg_wt)
`endif
  );

  sha256_unit u_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .round     (round),
    .Kt        (kt),
    .M         (b_m),
    .Hin       (b_hin),
    .Hout      (b_hout)
`ifdef SHA256_UNIT_DEBUG_EN
    ,
    .dbg_state (b_dbg_state),
    .dbg_wt    (b_dbg_wt)
`endif
  );

`ifdef SHA256_UNIT_DEBUG_EN
  logic [255:0] a_dbg_state;
  logic [31:0]  a_dbg_wt;
  logic [255:0] b_dbg_state;
  logic [31:0]  b_dbg_wt;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Hout of a unit whose state is all zero: T1 = Kt (everything else is
  // zero), T2 = 0, so the next state is {Kt,0,0,0,Kt,0,0,0}.
  function automatic logic [255:0] zero_state_hout(input logic [255:0] hin_v,
                                                   input logic [31:0] k_v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = hin_v[i*32 +: 32] + (((i == 7) || (i == 3)) ? k_v : 32'd0);
    end
    return r;
  endfunction

  task automatic check256(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Controller: advance one round after the edge, Kt = K[round-1]
  // (or the misaligned K[round] when lag is set).
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      round = round + 6'd1;
      kt    = lag ? k_rom[round] : k_rom[round - 6'd1];
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    k_rom = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    total   = 0;
    bad     = 0;
    lag     = 1'b0;
    reset_n = 1'b0;
    round   = 6'd0;
    kt      = 32'hc67178f2;
    a_m     = '0;
    a_hin   = '0;
    b_m_low = '0;
    b_hin   = IV;

    // Reset state: S and W are zero, so Hout shows only Hin and Kt.
    #2;
    check256("reset_hout_hin0", a_hout, 256'hc67178f2_00000000_00000000_00000000_c67178f2_00000000_00000000_00000000);
    a_hin = IV;
    #1;
    check256("reset_hout_iv", a_hout, zero_state_hout(IV, 32'hc67178f2));
    check256("reset_hout_b", b_hout, zero_state_hout(IV, 32'hc67178f2));
`ifdef SHA256_UNIT_DEBUG_EN
    check256("reset_dbg_state", a_dbg_state, 256'd0);
    check32("reset_dbg_wt", a_dbg_wt, 32'd0);
`endif

    // Test 1: "abc" single block from the IV.
    @(negedge clk);
    reset_n = 1'b1;
    a_m     = M_ABC;
    a_hin   = IV;
    tick(64);
    #1;
    check256("abc_digest", a_hout, D_ABC);

    // Test 2 back-to-back: Bitcoin header block 2 from its midstate.
    a_m   = M_BTC;
    a_hin = H_BTC;
    #1;
    tick(64);
    #1;
    check256("btc_block2_digest", a_hout, D_BTC);

    // Test 3: unit B hashes A's digest. A's Hin stays put so its Hout (and
    // so B's top M word) holds through the load edge; A repeats block 2.
    b_m_low = {a_hout[223:0], 1'b1, 191'd0, 64'h100};
    b_hin   = IV;
    #1;
    tick(64);
    #1;
    check256("double_sha_b_digest", b_hout, D_DBL);
    check256("btc_block2_repeat", a_hout, D_BTC);

    // Test 5: reset in the middle of a block.
    a_m   = M_ABC;
    a_hin = IV;
    #1;
    tick(30);
    #2;
    reset_n = 1'b0;
    #1;
    check256("midreset_hout_a", a_hout, zero_state_hout(IV, k_rom[29]));
    check256("midreset_hout_b", b_hout, zero_state_hout(IV, k_rom[29]));
`ifdef SHA256_UNIT_DEBUG_EN
    check256("midreset_dbg_state", a_dbg_state, 256'd0);
`endif
    // Reset dominates a clock edge with a nonzero round.
    tick(1);
    #1;
    check256("reset_held_edge", a_hout, zero_state_hout(IV, k_rom[30]));

    // Restart cleanly from round 0 with "abc".
    round = 6'd0;
    kt    = k_rom[63];
    #1;
    reset_n = 1'b1;
    tick(1);
`ifdef SHA256_UNIT_DEBUG_EN
    #1;
    check256("restart_load_state", a_dbg_state, IV);
    check32("restart_load_wt", a_dbg_wt, 32'h61626380);
`endif
    tick(1);
`ifdef SHA256_UNIT_DEBUG_EN
    #1;
    check256("restart_step0_state", a_dbg_state, S_ABC_T0);
    check32("restart_step1_wt", a_dbg_wt, 32'd0);
`endif
    tick(62);
    #1;
    check256("restart_abc_digest", a_hout, D_ABC);

    // Test 6: Kt one round early must corrupt the digest.
    lag = 1'b1;
    kt  = k_rom[round];
    #1;
    tick(64);
    #1;
    total++;
    assert (a_hout !== D_ABC) else begin
      bad++;
      $error("FAIL kt_lag_digest observed=%h required to differ from %h", a_hout, D_ABC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
